// File: rtl/seq_loop_pkg.sv
// Shared types and helpers for the register-broken AND/NAND loop chain.
// Holds the FSM state encoding, the branch tap placement and the window counter width.
package seq_loop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIN_DEF = 16;
    localparam int WCNT_W  = $clog2(WIN_DEF);

    // Branches tap the main chain at evenly spaced points, never the last stage.
    function automatic int tap_idx(input int b, input int depth, input int branches);
        return ((b + 1) * depth) / (branches + 1);
    endfunction

    function automatic int wcnt_width(input int win);
        return (win > 2) ? $clog2(win) : 1;
    endfunction

endpackage

// File: rtl/loop_branch.sv
// N-stage AND chain with every stage exposed, closed by an output NAND.
// Used for the side branches and, with N=DEPTH-1, for the tail of the main chain.
module loop_branch #(
    parameter int N = 3
) (
    input  logic         a,
    input  logic [N-1:0] en,
    output logic [N-1:0] stg,
    output logic         y
);

    // Ripple the input through the enables, recording every stage.
    always_comb begin
        logic acc_s;
        stg   = '0;
        acc_s = a;
        for (int i = 0; i < N; i++) begin
            acc_s  = acc_s & en[i];
            stg[i] = acc_s;
        end
    end

    assign y = ~stg[N-1];

endmodule

// File: rtl/seq_loop_chain.sv
// AND chain closed through a NAND and a single flop, with side branches feeding the loop node.
// A small FSM runs the loop for WIN updates, counting toggles and judging oscillation.
module seq_loop_chain
    import seq_loop_pkg::*;
#(
    parameter int   DEPTH    = 8,
    parameter int   BRANCHES = 2,
    parameter int   BR_DEPTH = 3,
    parameter int   WIN      = 16,
    parameter int   CNT_W    = 8,
    parameter logic INIT     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DEPTH-1:0]             pin,
    input  logic [BRANCHES*BR_DEPTH-1:0] bpin,
    output logic                         loop_q,
    output logic [CNT_W-1:0]             toggle_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         oscillating
);

    localparam int WC_W = wcnt_width(WIN);

    state_e                           state_r;
    state_e                           state_nx_s;
    logic   [WC_W-1:0]                wcnt_r;
    logic   [DEPTH-1:0]               s_s;
    logic   [DEPTH-2:0]               main_stg_s;
    logic                             m_s;
    logic   [BRANCHES-1:0]            br_s;
    logic   [BRANCHES*BR_DEPTH-1:0]   br_stg_s;
    logic                             q_next_s;
    logic                             toggle_s;
    logic                             last_s;
    logic                             stg_unused_s;

    assign s_s[0] = loop_q & pin[0];

    loop_branch #(.N(DEPTH-1)) u_main (
        .a   (s_s[0]),
        .en  (pin[DEPTH-1:1]),
        .stg (main_stg_s),
        .y   (m_s)
    );

    assign s_s[DEPTH-1:1] = main_stg_s;

    for (genvar b = 0; b < BRANCHES; b++) begin : g_br
        localparam int TAP = tap_idx(b, DEPTH, BRANCHES);
        loop_branch #(.N(BR_DEPTH)) u_br (
            .a   (s_s[TAP]),
            .en  (bpin[b*BR_DEPTH +: BR_DEPTH]),
            .stg (br_stg_s[b*BR_DEPTH +: BR_DEPTH]),
            .y   (br_s[b])
        );
    end

    // Intermediate stages only matter through taps and outputs.
    assign stg_unused_s = ^{s_s, br_stg_s};

    assign q_next_s = m_s & (&br_s);
    assign toggle_s = q_next_s != loop_q;
    assign last_s   = wcnt_r == WC_W'(WIN - 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Loop node, window counter, toggle count and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_q      <= INIT;
            toggle_cnt  <= '0;
            wcnt_r      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            oscillating <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        loop_q      <= INIT;
                        toggle_cnt  <= '0;
                        wcnt_r      <= '0;
                        oscillating <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    loop_q <= q_next_s;
                    wcnt_r <= wcnt_r + WC_W'(1);
                    if (toggle_s && (toggle_cnt != {CNT_W{1'b1}})) begin
                        toggle_cnt <= toggle_cnt + CNT_W'(1);
                    end
                    if (last_s) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        oscillating <= toggle_s;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_loop_chain.sv
// Directed bench for seq_loop_chain: a default instance plus a CNT_W=3 instance sharing stimulus.
module tb_seq_loop_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] pin;
    logic [5:0] bpin;

    logic       a_loop_q, a_busy, a_done, a_osc;
    logic [7:0] a_cnt;
    logic       b_loop_q, b_busy, b_done, b_osc;
    logic [2:0] b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    seq_loop_chain u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pin         (pin),
        .bpin        (bpin),
        .loop_q      (a_loop_q),
        .toggle_cnt  (a_cnt),
        .busy        (a_busy),
        .done        (a_done),
        .oscillating (a_osc)
    );

    seq_loop_chain #(.CNT_W(3)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pin         (pin),
        .bpin        (bpin),
        .loop_q      (b_loop_q),
        .toggle_cnt  (b_cnt),
        .busy        (b_busy),
        .done        (b_done),
        .oscillating (b_osc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_loop_q"}, {31'd0, a_loop_q}, 32'd0);
        chk({tag, "_cnt"},    {24'd0, a_cnt},    32'd0);
        chk({tag, "_busy"},   {31'd0, a_busy},   32'd0);
        chk({tag, "_done"},   {31'd0, a_done},   32'd0);
        chk({tag, "_osc"},    {31'd0, a_osc},    32'd0);
        chk({tag, "_sat_cnt"}, {29'd0, b_cnt},   32'd0);
    endtask

    // One full window: start edge, 15 quiet updates, final update with done, then done drops.
    task automatic run_window(input string tag, input logic [7:0] exp_cnt, input logic exp_osc,
                              input logic [2:0] exp_sat, input logic exp_final,
                              input logic alt, input logic repulse);
        int dones;
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_busy"},   {31'd0, a_busy},   32'd1);
        chk({tag, "_start_loop_q"}, {31'd0, a_loop_q}, 32'd0);
        chk({tag, "_start_cnt"},    {24'd0, a_cnt},    32'd0);
        chk({tag, "_start_osc"},    {31'd0, a_osc},    32'd0);
        for (int k = 1; k < 16; k++) begin
            start = repulse && (k == 3 || k == 10);
            tick();
            dones += int'(a_done) + int'(b_done);
            if (alt) chk({tag, "_alt"}, {31'd0, a_loop_q}, {31'd0, k[0]});
        end
        start = 1'b0;
        chk({tag, "_early_done"}, dones, 32'd0);
        tick();
        chk({tag, "_done"},    {31'd0, a_done},   32'd1);
        chk({tag, "_busy_lo"}, {31'd0, a_busy},   32'd0);
        chk({tag, "_cnt"},     {24'd0, a_cnt},    {24'd0, exp_cnt});
        chk({tag, "_osc"},     {31'd0, a_osc},    {31'd0, exp_osc});
        chk({tag, "_final"},   {31'd0, a_loop_q}, {31'd0, exp_final});
        chk({tag, "_sat_cnt"}, {29'd0, b_cnt},    {29'd0, exp_sat});
        chk({tag, "_sat_osc"}, {31'd0, b_osc},    {31'd0, exp_osc});
        tick();
        chk({tag, "_done_pulse"}, {31'd0, a_done}, 32'd0);
        chk({tag, "_hold_cnt"},   {24'd0, a_cnt},  {24'd0, exp_cnt});
        tick();
        chk({tag, "_idle_loop_q"}, {31'd0, a_loop_q}, {31'd0, exp_final});
        chk({tag, "_idle_osc"},    {31'd0, a_osc},    {31'd0, exp_osc});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pin   = 8'hFF;
        bpin  = 6'h3F;
        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Fully enabled loop inverts every update.
        run_window("all_ones", 8'd16, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);

        // pin[0]=0 forces the node high after one update.
        pin = 8'hFE;
        run_window("pin0_low", 8'd1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);

        // Branch 0 disabled: its NAND is stuck at 1, loop still inverts.
        pin  = 8'hFF;
        bpin = 6'b111_000;
        run_window("br0_off", 8'd16, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);

        // Last main stage off: m=1 but both branches still invert loop_q.
        pin  = 8'h7F;
        bpin = 6'h3F;
        run_window("pin7_low", 8'd16, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);

        // pin[1]=0 kills both taps, so everything settles high.
        pin = 8'hFD;
        run_window("pin1_low", 8'd1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);

        // Restart from INIT after a settled-high window, with ignored start pulses.
        pin = 8'hFF;
        run_window("repulse", 8'd16, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a window.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk("mid_busy", {31'd0, a_busy}, 32'd1);
        chk("mid_cnt",  {24'd0, a_cnt},  32'd5);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("async_rst");
        tick();
        tick();
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk("no_done_after_rst", {31'd0, a_done}, 32'd0);
        run_window("post_rst", 8'd16, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
